bus_dma: RTL and testbench
==========================

BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 Parameter CH, default 2, number of independent DMA channels (1..8).
REQ-002 Parameter LEN_W, default 9, width of the per-channel length field; maximum transfer is 2^LEN_W-1 bytes.
REQ-003 clock  input  1  system clock; the only clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ce  input  1  clock enable; state advances only on rising clock edges with ce=1.
REQ-006 start  input  CH  per-channel one-cycle start request, sampled when ce=1.
REQ-007 cfg_src  input  16*CH  per-channel source base address; channel k occupies bits [16k+15:16k].
REQ-008 cfg_dst  input  16*CH  per-channel destination address, same packing as cfg_src.
REQ-009 cfg_len  input  LEN_W*CH  per-channel byte count.
REQ-010 cfg_dinc  input  CH  per channel: 1 = destination increments per byte; 0 = destination is fixed (port-style, e.g. $2004).
REQ-011 halt  output  1  high while the CPU must be stalled; the integrator ANDs ~halt into the CPU ce.
REQ-012 busy  output  CH  channel pending or active.
REQ-013 done  output  CH  one-ce-cycle pulse when a channel completes.
REQ-014 A  output  16  bus address.
REQ-015 I  input  8  bus read data; valid in the same ce cycle that R is high.
REQ-016 D  output  8  bus write data.
REQ-017 R  output  1  read strobe.
REQ-018 W  output  1  write strobe.

Function
REQ-019 Start handling: start[k]=1 with busy[k]=0 and cfg_len[k]!=0 sets busy[k] on that edge.
REQ-020 Start ignored: start[k] while busy[k]=1 has no effect.
REQ-021 Zero length: start[k] with cfg_len[k]=0 pulses done[k] on the next ce cycle, with no bus cycles and no halt.
REQ-022 Config latching: cfg_src, cfg_dst, cfg_len and cfg_dinc for a channel are latched when that channel is granted; later changes do not affect the running transfer.
REQ-023 Arbitration: in IDLE, the lowest-index busy channel is granted.
REQ-024 No preemption: an active transfer is never preempted.
REQ-025 States: IDLE, HALT, ALIGN, READ, WRITE, DONE; every transition occurs only when ce=1.
REQ-026 Parity counter: a free-running 1-bit parity counter toggles on every ce cycle, including while idle, and resets to 0.
REQ-027 IDLE -> HALT on grant; halt asserts in HALT and stays high through DONE inclusive.
REQ-028 HALT -> ALIGN if parity=1, else HALT -> READ; ALIGN -> READ.
REQ-029 READ cycle: A=src+idx, R=1, W=0; the I value is latched into the data register on that edge.
REQ-030 WRITE cycle: A=dst+idx if dinc=1, else A=dst; W=1, R=0; D=data register.
REQ-031 Byte loop: WRITE -> READ with idx+1 while idx<len-1; WRITE -> DONE when idx=len-1.
REQ-032 Address arithmetic is modulo 2^16; src+idx wraps from $FFFF to $0000.
REQ-033 DONE cycle: done[k]=1, busy[k] cleared, R=W=0; DONE -> IDLE.
REQ-034 Back-to-back: another pending channel is granted on the following IDLE cycle, so there is at least one cycle with halt=0 between transfers.
REQ-035 Outside READ/WRITE: R=0, W=0, A=0, D holds its last value.
REQ-036 Stall: with ce=0, all outputs and state hold, and done pulses are held rather than repeated.
REQ-037 Timing: a transfer of N bytes occupies 2N+2 ce cycles with halt=1 if parity=0 at HALT, or 2N+3 if parity=1.

Reset
REQ-038 Reset clears state to IDLE, idx=0, parity=0, busy=0, done=0, halt=0, R=0, W=0, A=0, D=0, and all latched config.
REQ-039 Reset mid-transfer: reset asserted during a transfer aborts it immediately, with no done pulse and no further bus cycles; pending starts are discarded.

Verification
REQ-040 Parity 0, fixed destination: ch0 src=$0200 dst=$2004 dinc=0 len=256, started with parity=0 -> 256 read/write pairs with A=$0200..$02FF reads and every write to $2004; D equals memory bytes; halt high for exactly 514 ce cycles; one done[0] pulse.
REQ-041 Parity 1: the same start issued with parity=1 -> one ALIGN cycle, halt high for 515 cycles, and the first READ is delayed by one cycle.
REQ-042 Simultaneous starts: start=2'b11 with ch0 len=3 and ch1 len=2, dst $3000 dinc=1 -> ch0 completes first, one halt=0 gap, then ch1 writes $3000,$3001; done[0] precedes done[1].
REQ-043 Stall and wrap: ce toggled 1,0,0,1 throughout a len=4 transfer from src=$FFFE -> reads $FFFE,$FFFF,$0000,$0001; no strobe changes while ce=0; done lasts one ce cycle.
REQ-044 Zero length and restart-while-busy: start with len=0 -> done next ce cycle, halt never high; start[0] re-pulsed mid-transfer -> ignored, byte count unchanged.
REQ-045 Reset abort: reset during the third WRITE -> halt, R, W drop asynchronously; busy=0; no done; a subsequent start runs normally from idx=0.

Source files
------------

// File: rtl/bus_dma.sv
// Multi-channel byte DMA: stalls the CPU through halt, then copies bytes with
// alternating read/write bus cycles, optionally aligned by one cycle to the parity counter.
//   state  | meaning
//   IDLE   | no transfer; grant the lowest-index busy channel
//   HALT   | CPU stalled; parity decides whether an ALIGN cycle is needed
//   ALIGN  | one padding cycle so the first read lands on the other parity
//   READ   | A=src+idx, R=1, capture I
//   WRITE  | A=dst(+idx), W=1, D=captured byte
//   DONE   | done pulse for the finished channel, then back to IDLE
module bus_dma #(
    parameter int CH    = 2,
    parameter int LEN_W = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ce,
    input  logic [CH-1:0]         start,
    input  logic [16*CH-1:0]      cfg_src,
    input  logic [16*CH-1:0]      cfg_dst,
    input  logic [LEN_W*CH-1:0]   cfg_len,
    input  logic [CH-1:0]         cfg_dinc,
    output logic                  halt,
    output logic [CH-1:0]         busy,
    output logic [CH-1:0]         done,
    output logic [15:0]           A,
    input  logic [7:0]            I,
    output logic [7:0]            D,
    output logic                  R,
    output logic                  W
);
    localparam int CW = (CH > 1) ? $clog2(CH) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HALT  = 3'd1;
    localparam logic [2:0] S_ALIGN = 3'd2;
    localparam logic [2:0] S_READ  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]       state;
    logic             parity;
    logic [CH-1:0]    busy_q;
    logic [CH-1:0]    done_q;
    logic [CW-1:0]    cur;
    logic [15:0]      src;
    logic [15:0]      dst;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] idx;
    logic             dinc;
    logic [7:0]       data;

    logic             gnt_ok;
    logic [CW-1:0]    gnt_ch;
    logic [15:0]      gnt_src;
    logic [15:0]      gnt_dst;
    logic [LEN_W-1:0] gnt_len;
    logic             gnt_dinc;
    logic [CH-1:0]    len_nz;
    logic [CH-1:0]    start_ok;
    logic [CH-1:0]    zero_len;
    logic [CH-1:0]    fin_mask;
    logic             last;
    logic [15:0]      idx16;

    // Descending scan so the lowest-index busy channel wins.
    always_comb begin
        gnt_ok   = 1'b0;
        gnt_ch   = '0;
        gnt_src  = '0;
        gnt_dst  = '0;
        gnt_len  = '0;
        gnt_dinc = 1'b0;
        for (int k = CH - 1; k >= 0; k--) begin
            if (busy_q[k]) begin
                gnt_ok   = 1'b1;
                gnt_ch   = CW'(k);
                gnt_src  = cfg_src[16*k +: 16];
                gnt_dst  = cfg_dst[16*k +: 16];
                gnt_len  = cfg_len[LEN_W*k +: LEN_W];
                gnt_dinc = cfg_dinc[k];
            end
        end
    end

    always_comb begin
        len_nz = '0;
        for (int k = 0; k < CH; k++) begin
            len_nz[k] = |cfg_len[LEN_W*k +: LEN_W];
        end
    end

    assign start_ok = start & ~busy_q & len_nz;
    assign zero_len = start & ~busy_q & ~len_nz;
    assign last     = (({1'b0, idx} + (LEN_W+1)'(1)) >= {1'b0, len});
    assign fin_mask = (state == S_WRITE && last) ? (CH'(1) << cur) : '0;
    assign idx16    = 16'(idx);

    assign halt = (state != S_IDLE);
    assign R    = (state == S_READ);
    assign W    = (state == S_WRITE);
    assign D    = data;
    assign busy = busy_q;
    assign done = done_q;

    always_comb begin
        A = 16'h0000;
        if (state == S_READ) begin
            A = src + idx16;
        end else if (state == S_WRITE) begin
            A = dinc ? (dst + idx16) : dst;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            parity <= 1'b0;
            busy_q <= '0;
            done_q <= '0;
            cur    <= '0;
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            idx    <= '0;
            dinc   <= 1'b0;
            data   <= '0;
        end else if (ce) begin
            parity <= ~parity;
            done_q <= zero_len | fin_mask;
            busy_q <= (busy_q | start_ok) & ~fin_mask;
            case (state)
                S_IDLE: begin
                    if (gnt_ok) begin
                        state <= S_HALT;
                        cur   <= gnt_ch;
                        src   <= gnt_src;
                        dst   <= gnt_dst;
                        len   <= gnt_len;
                        dinc  <= gnt_dinc;
                        idx   <= '0;
                    end
                end
                S_HALT:  state <= parity ? S_ALIGN : S_READ;
                S_ALIGN: state <= S_READ;
                S_READ: begin
                    data  <= I;
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (last) begin
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= S_READ;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bus_dma.sv
// Scoreboard bench for bus_dma: stimulus pushes expected bus cycles, halt lengths,
// first-read lead and done pulses; a negedge monitor pops and compares them.
module tb_bus_dma;
    localparam int CH    = 2;
    localparam int LEN_W = 9;

    logic                clock;
    logic                reset;
    logic                ce;
    logic [CH-1:0]       start;
    logic [16*CH-1:0]    cfg_src;
    logic [16*CH-1:0]    cfg_dst;
    logic [LEN_W*CH-1:0] cfg_len;
    logic [CH-1:0]       cfg_dinc;
    logic                halt;
    logic [CH-1:0]       busy;
    logic [CH-1:0]       done;
    logic [15:0]         A;
    logic [7:0]          I;
    logic [7:0]          D;
    logic                R;
    logic                W;

    logic [7:0] mem [0:65535];
    assign I = R ? mem[A] : 8'h00;

    typedef struct packed {
        logic        w;
        logic [15:0] a;
        logic [7:0]  d;
    } bus_t;

    bus_t exp_bus[$];
    int   exp_done[$];
    int   exp_halt[$];
    int   exp_lead[$];

    int   checks   = 0;
    int   failures = 0;
    bit   tb_par;
    bit   stall_mode = 1'b0;
    int   ph = 0;
    bit   aborted = 1'b0;
    logic [3:0] pat = 4'b1001;

    bus_dma #(.CH(CH), .LEN_W(LEN_W)) dut (
        .clock(clock), .reset(reset), .ce(ce), .start(start),
        .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len), .cfg_dinc(cfg_dinc),
        .halt(halt), .busy(busy), .done(done), .A(A), .I(I), .D(D), .R(R), .W(W)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock or posedge reset) begin
        if (reset) tb_par <= 1'b0;
        else if (ce) tb_par <= ~tb_par;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=unexpected-or-timeout required=none", name);
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
        if (stall_mode) begin
            ce = pat[ph];
            ph = (ph + 1) % 4;
        end
    endtask

    task automatic set_ch(input int ch, input logic [15:0] s, input logic [15:0] d,
                          input logic [LEN_W-1:0] l, input logic di);
        cfg_src[16*ch +: 16]       = s;
        cfg_dst[16*ch +: 16]       = d;
        cfg_len[LEN_W*ch +: LEN_W] = l;
        cfg_dinc[ch]               = di;
    endtask

    task automatic expect_xfer(input int ch, input logic [15:0] s, input logic [15:0] d,
                               input int n, input bit di, input bit par, input bit full);
        bus_t e;
        logic [15:0] a;
        for (int i = 0; i < n; i++) begin
            a   = s + 16'(i);
            e.w = 1'b0; e.a = a; e.d = 8'h00;
            exp_bus.push_back(e);
            e.w = 1'b1; e.a = di ? (d + 16'(i)) : d; e.d = mem[a];
            exp_bus.push_back(e);
        end
        exp_lead.push_back(par ? 2 : 1);
        if (full) begin
            exp_halt.push_back(2 * n + 2 + (par ? 1 : 0));
            exp_done.push_back(ch);
        end
    endtask

    task automatic kick(input logic [CH-1:0] mask, input bit want_par);
        int n = 0;
        while ((tb_par != want_par || ce != 1'b1) && n < 20) begin
            cyc();
            n++;
        end
        start = mask;
        cyc();
        start = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(busy == '0 && !halt) && n < budget) begin
            cyc();
            n++;
        end
        if (n >= budget) miss("wait_idle_timeout");
    endtask

    // Monitor: one pop per ce cycle that presents a bus cycle, done pulse or halt edge.
    initial begin
        bit          prev_ok = 1'b0;
        bit          prev_ce = 1'b0;
        logic [30:0] prev_snap = '0;
        logic [30:0] snap;
        int          halt_run = 0;
        bit          lead_seen = 1'b0;
        bus_t        e;
        int          c;
        forever begin
            @(negedge clock);
            snap = {halt, R, W, A, D, done, busy};
            if (reset) begin
                prev_ok = 1'b0;
            end else begin
                if (prev_ok && !prev_ce) chk("stall_hold", 32'(snap), 32'(prev_snap));
                if (ce) begin
                    if (R || W) begin
                        chk("rw_exclusive", 32'(R & W), 32'(0));
                        if (exp_bus.size() == 0) miss("bus_extra");
                        else begin
                            e = exp_bus.pop_front();
                            chk("bus_dir", 32'(W), 32'(e.w));
                            chk("bus_addr", 32'(A), 32'(e.a));
                            if (W) chk("bus_data", 32'(D), 32'(e.d));
                        end
                    end
                    if (done != '0) begin
                        if (exp_done.size() == 0) miss("done_extra");
                        else begin
                            c = exp_done.pop_front();
                            chk("done_ch", 32'(done), 32'(1) << c);
                        end
                    end
                    if (halt) begin
                        halt_run++;
                        if (R && !lead_seen) begin
                            lead_seen = 1'b1;
                            if (exp_lead.size() == 0) miss("lead_extra");
                            else chk("first_read_lead", 32'(halt_run - 1), 32'(exp_lead.pop_front()));
                        end
                    end else if (halt_run > 0) begin
                        if (aborted) aborted = 1'b0;
                        else if (exp_halt.size() == 0) miss("halt_extra");
                        else chk("halt_cycles", 32'(halt_run), 32'(exp_halt.pop_front()));
                        halt_run  = 0;
                        lead_seen = 1'b0;
                    end
                end
                prev_ok   = 1'b1;
                prev_ce   = ce;
                prev_snap = snap;
            end
        end
    end

    initial begin
        int n;
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'(a >> 8) ^ 8'hA5;
        reset = 1'b1; ce = 1'b1; start = '0;
        cfg_src = '0; cfg_dst = '0; cfg_len = '0; cfg_dinc = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_halt", 32'(halt), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_R", 32'(R), 32'(0));
        chk("rst_W", 32'(W), 32'(0));
        chk("rst_A", 32'(A), 32'(0));
        chk("rst_D", 32'(D), 32'(0));
        reset = 1'b0;
        cyc(); cyc();

        // 256 bytes to a fixed port, parity 0 then parity 1
        set_ch(0, 16'h0200, 16'h2004, 9'd256, 1'b0);
        expect_xfer(0, 16'h0200, 16'h2004, 256, 1'b0, 1'b0, 1'b1);
        kick(2'b01, 1'b0);
        wait_idle(1000);
        expect_xfer(0, 16'h0200, 16'h2004, 256, 1'b0, 1'b1, 1'b1);
        kick(2'b01, 1'b1);
        wait_idle(1000);

        // simultaneous starts; ch0 config scrambled after its grant
        set_ch(0, 16'h1000, 16'h4000, 9'd3, 1'b1);
        set_ch(1, 16'h1100, 16'h3000, 9'd2, 1'b1);
        expect_xfer(0, 16'h1000, 16'h4000, 3, 1'b1, 1'b0, 1'b1);
        expect_xfer(1, 16'h1100, 16'h3000, 2, 1'b1, 1'b1, 1'b1);
        kick(2'b11, 1'b0);
        cyc();
        set_ch(0, 16'hDEAD, 16'hBEEF, 9'd9, 1'b0);
        wait_idle(200);

        // stall pattern with source wrap
        stall_mode = 1'b1;
        set_ch(0, 16'hFFFE, 16'h5000, 9'd4, 1'b1);
        expect_xfer(0, 16'hFFFE, 16'h5000, 4, 1'b1, 1'b0, 1'b1);
        kick(2'b01, 1'b0);
        wait_idle(400);
        stall_mode = 1'b0;
        ce = 1'b1;
        cyc(); cyc();

        // zero length
        set_ch(1, 16'h0000, 16'h0000, 9'd0, 1'b0);
        exp_done.push_back(1);
        start = 2'b10;
        cyc();
        start = '0;
        chk("zero_len_done", 32'(done), 32'(2'b10));
        chk("zero_len_halt", 32'(halt), 32'(0));
        chk("zero_len_busy", 32'(busy), 32'(0));
        cyc();
        chk("zero_len_done_clear", 32'(done), 32'(0));

        // restart while busy is ignored
        set_ch(0, 16'h0400, 16'h7000, 9'd5, 1'b1);
        expect_xfer(0, 16'h0400, 16'h7000, 5, 1'b1, 1'b0, 1'b1);
        kick(2'b01, 1'b0);
        repeat (6) cyc();
        set_ch(0, 16'h0400, 16'h7000, 9'd7, 1'b1);
        start = 2'b01;
        cyc();
        start = '0;
        wait_idle(200);
        cyc(); cyc();

        // reset during the third write, with ch1 pending
        set_ch(0, 16'h0300, 16'h6000, 9'd6, 1'b1);
        set_ch(1, 16'h0500, 16'h6100, 9'd3, 1'b1);
        expect_xfer(0, 16'h0300, 16'h6000, 3, 1'b1, 1'b0, 1'b0);
        kick(2'b11, 1'b0);
        n = 0;
        while (!(W && A == 16'h6002) && n < 100) begin
            cyc();
            n++;
        end
        if (n >= 100) miss("third_write_timeout");
        @(negedge clock);
        #2;
        aborted = 1'b1;
        reset = 1'b1;
        #1;
        chk("abort_halt", 32'(halt), 32'(0));
        chk("abort_R", 32'(R), 32'(0));
        chk("abort_W", 32'(W), 32'(0));
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_done", 32'(done), 32'(0));
        @(posedge clock);
        #1;
        reset = 1'b0;
        cyc(); cyc();
        chk("post_abort_busy", 32'(busy), 32'(0));
        set_ch(0, 16'h0300, 16'h6000, 9'd2, 1'b1);
        expect_xfer(0, 16'h0300, 16'h6000, 2, 1'b1, 1'b0, 1'b1);
        kick(2'b01, 1'b0);
        wait_idle(200);
        repeat (4) cyc();

        chk("left_bus", 32'(exp_bus.size()), 32'(0));
        chk("left_done", 32'(exp_done.size()), 32'(0));
        chk("left_halt", 32'(exp_halt.size()), 32'(0));
        chk("left_lead", 32'(exp_lead.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
